// File: rtl/rank_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rank_filter_pkg
// Description : Shared types and helpers for the serial rank-order filter.
//               Holds the controller state encoding and the pass-count /
//               sort-direction helpers derived from the latched rank.
// Revision    : 1.0  initial release
// ============================================================================
package rank_filter_pkg;

  // Controller states: collect first sample, collect rest, sort, present.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Number of extraction passes: walk in from whichever end is nearer.
  function automatic int n_passes(input int rk, input int num);
    int from_min;
    int from_max;
    from_min = rk + 1;
    from_max = num - rk;
    return (from_min < from_max) ? from_min : from_max;
  endfunction

  // Extract maxima when the rank is at least as close to the top end.
  function automatic logic max_mode(input int rk, input int num);
    return ((num - rk) <= (rk + 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rank_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : rank_filter_if
// Description : Sample-in / result-out handshake bundle of the rank filter.
//               master = upstream/downstream side, slave = filter side.
// Revision    : 1.0  initial release
// ============================================================================
interface rank_filter_if #(
  parameter int WIDTH = 8,
  parameter int NUM   = 9
);
  localparam int RW = $clog2(NUM);

  logic [WIDTH-1:0] DI;
  logic             DSI;
  logic             DI_RDY;
  logic [RW-1:0]    RANK;
  logic [WIDTH-1:0] DO;
  logic             DSO;
  logic             DOR;

  modport master (
    output DI, DSI, RANK, DOR,
    input  DI_RDY, DO, DSO
  );

  modport slave (
    input  DI, DSI, RANK, DOR,
    output DI_RDY, DO, DSO
  );

endinterface
`default_nettype wire

// File: rtl/rank_filter_core.sv
`default_nettype none
// ============================================================================
// Module      : rank_core
// Description : Circular sample buffer plus accumulator. Each step compares
//               the buffer tail with the accumulator; the winner stays in the
//               accumulator, the loser re-enters the buffer head. A pass of
//               NUM steps therefore extracts one extreme value.
// Revision    : 1.0  initial release
// ============================================================================
module rank_core #(
  parameter int WIDTH = 8,
  parameter int NUM   = 9
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pass_start_i,
  input  logic             step_i,
  input  logic             max_mode_i,
  output logic [WIDTH-1:0] a_o
);

  logic [WIDTH-1:0] b_q [NUM];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] acc_cmp;
  logic [WIDTH-1:0] head_in;
  logic             tail_wins;

  assign tail = b_q[NUM-1];

  // Compare stage: sentinel replaces A on the first step of a pass; ties keep A.
  always_comb begin
    acc_cmp   = pass_start_i ? (max_mode_i ? '0 : '1) : a_q;
    tail_wins = max_mode_i ? (tail > acc_cmp) : (tail < acc_cmp);
    a_d       = a_q;
    head_in   = tail_wins ? acc_cmp : tail;
    if (load_i) begin
      head_in = din_i;
    end else if (step_i) begin
      a_d = tail_wins ? tail : acc_cmp;
    end
  end

  // Buffer rotates on every load or sort step; accumulator takes the winner.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      a_q <= '0;
      for (int i = 0; i < NUM; i++) begin
        b_q[i] <= '0;
      end
    end else begin
      a_q <= a_d;
      if (load_i || step_i) begin
        b_q[0] <= head_in;
        for (int i = 1; i < NUM; i++) begin
          b_q[i] <= b_q[i-1];
        end
      end
    end
  end

  // Accumulator value including this cycle's compare, so the controller can
  // capture the final result on the same edge that ends the last pass.
  assign a_o = a_d;

endmodule
`default_nettype wire

// File: rtl/rank_filter.sv
`default_nettype none
// ============================================================================
// Module      : rank_filter
// Description : Serial rank-order filter. Collects NUM samples, runs
//               P = min(rk+1, NUM-rk) extraction passes of NUM cycles each and
//               presents the rk-th smallest sample over a valid/ready port.
// Revision    : 1.0  initial release
// ============================================================================
module rank_filter
  import rank_filter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM   = 9
) (
  input  logic        CLK,
  input  logic        nRST,
  rank_filter_if.slave bus
);

  localparam int RW = $clog2(NUM);
  localparam int CW = $clog2(NUM);
  localparam int PW = $clog2(NUM + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    smp_q, smp_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [RW-1:0]    rk_q, rk_d;
  logic [WIDTH-1:0] do_q, do_d;

  logic             rdy;
  logic             accept;
  logic             load;
  logic             step;
  logic             pass_start;
  logic             mode;
  logic [PW-1:0]    n_pass;
  logic [RW-1:0]    rank_clamped;
  logic [WIDTH-1:0] a_next;

  assign rdy          = (state_q == IDLE) || (state_q == LOAD);
  assign accept       = bus.DSI && rdy;
  assign rank_clamped = (32'(bus.RANK) >= NUM) ? RW'(NUM - 1) : bus.RANK;
  assign n_pass       = PW'(n_passes(int'(rk_q), NUM));
  assign mode         = max_mode(int'(rk_q), NUM);

  rank_core #(
    .WIDTH (WIDTH),
    .NUM   (NUM)
  ) u_core (
    .CLK          (CLK),
    .nRST         (nRST),
    .load_i       (load),
    .din_i        (bus.DI),
    .pass_start_i (pass_start),
    .step_i       (step),
    .max_mode_i   (mode),
    .a_o          (a_next)
  );

  // Next-state and datapath control: counters advance, result captured on entry to OUT.
  always_comb begin
    state_d    = state_q;
    smp_d      = smp_q;
    cyc_d      = cyc_q;
    pass_d     = pass_q;
    rk_d       = rk_q;
    do_d       = do_q;
    load       = 1'b0;
    step       = 1'b0;
    pass_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rk_d    = rank_clamped;
          load    = 1'b1;
          smp_d   = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          load = 1'b1;
          if (smp_q == CW'(NUM - 1)) begin
            smp_d   = '0;
            cyc_d   = '0;
            pass_d  = PW'(1);
            state_d = SORT;
          end else begin
            smp_d = smp_q + CW'(1);
          end
        end
      end
      SORT: begin
        step       = 1'b1;
        pass_start = (cyc_q == '0);
        if (cyc_q == CW'(NUM - 1)) begin
          cyc_d = '0;
          if (pass_q == n_pass) begin
            do_d    = a_next;
            state_d = OUT;
          end else begin
            pass_d = pass_q + PW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      OUT: begin
        if (bus.DOR) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset discards any partial window or sort in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      smp_q   <= '0;
      cyc_q   <= '0;
      pass_q  <= '0;
      rk_q    <= '0;
      do_q    <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      cyc_q   <= cyc_d;
      pass_q  <= pass_d;
      rk_q    <= rk_d;
      do_q    <= do_d;
    end
  end

  assign bus.DI_RDY = rdy;
  assign bus.DO     = do_q;
  assign bus.DSO    = (state_q == OUT);

endmodule
`default_nettype wire

// File: tb/tb_rank_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rank_filter
// Description : Directed self-checking bench for rank_filter (WIDTH=8, NUM=9).
// Revision    : 1.0  initial release
// ============================================================================
module tb_rank_filter;

  logic CLK;
  logic nRST;
  int   vectors;
  int   miscompares;
  logic [7:0] win [9];

  rank_filter_if #(.WIDTH(8), .NUM(9)) bus ();

  rank_filter #(
    .WIDTH (8),
    .NUM   (9)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_win(input logic [71:0] v);
    for (int i = 0; i < 9; i++) win[i] = v[71-8*i -: 8];
  endtask

  // Sends win[] (optionally with DSI gaps), changes RANK after the first
  // accepted sample, then waits for DSO. lat is the cycle index of DSO
  // relative to the cycle t in which the last sample was accepted.
  task automatic run_window(input logic [3:0] rank, input logic [3:0] rank_late,
                            input bit gaps, output int lat, output logic [7:0] dout);
    int i;
    int guard;
    bit acc;
    bit phase;
    i = 0;
    guard = 0;
    phase = 1'b0;
    bus.RANK = rank;
    while (i < 9 && guard < 100) begin
      if (gaps && phase) begin
        bus.DSI = 1'b0;
      end else begin
        bus.DSI = 1'b1;
        bus.DI  = win[i];
      end
      phase = !phase;
      acc = bus.DSI && bus.DI_RDY;
      tick();
      guard++;
      if (acc) begin
        i++;
        if (i == 1) bus.RANK = rank_late;
      end
    end
    bus.DSI = 1'b0;
    lat = 1;
    while (bus.DSO !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    if (i != 9) lat = -1;
    dout = bus.DO;
  endtask

  task automatic test_reset();
    #2 nRST = 1'b0;
    #1;
    vectors++;
    if (bus.DSO !== 1'b0 || bus.DO !== 8'd0 || bus.DI_RDY !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: DSO=%b DO=%0d DI_RDY=%b, required 0/0/1", bus.DSO, bus.DO, bus.DI_RDY);
    end
    @(posedge CLK);
    #1 nRST = 1'b1;
    tick();
    vectors++;
    if (bus.DSO !== 1'b0 || bus.DI_RDY !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: DSO=%b DI_RDY=%b, required 0/1", bus.DSO, bus.DI_RDY);
    end
  endtask

  task automatic test_median();
    int lat;
    logic [7:0] dout;
    set_win(72'h09_03_07_01_05_08_02_06_04);
    run_window(4'd4, 4'd4, 1'b0, lat, dout);
    vectors++;
    if (lat !== 46) begin
      miscompares++;
      $display("FAIL median_latency: DSO at t+%0d, required t+46", lat);
    end
    vectors++;
    if (dout !== 8'd5) begin
      miscompares++;
      $display("FAIL median_value: DO=%0d, required 5", dout);
    end
    tick();
    vectors++;
    if (bus.DSO !== 1'b0 || bus.DO !== 8'd5 || bus.DI_RDY !== 1'b1) begin
      miscompares++;
      $display("FAIL median_handshake: DSO=%b DO=%0d DI_RDY=%b, required 0/5/1", bus.DSO, bus.DO, bus.DI_RDY);
    end
  endtask

  // rk=0 (MIN,P=1), rk=8 (MAX,P=1), rk=2 (MIN,P=3), rk=6 (MAX,P=3).
  task automatic test_rank_extremes();
    int rk_t  [4] = '{0, 8, 2, 6};
    int exp_t [4] = '{1, 9, 3, 7};
    int lat_t [4] = '{10, 10, 28, 28};
    int lat;
    logic [7:0] dout;
    set_win(72'h09_03_07_01_05_08_02_06_04);
    for (int j = 0; j < 4; j++) begin
      run_window(4'(rk_t[j]), 4'(rk_t[j]), 1'b0, lat, dout);
      vectors++;
      if (lat !== lat_t[j] || dout !== 8'(exp_t[j])) begin
        miscompares++;
        $display("FAIL rank_%0d: DO=%0d at t+%0d, required DO=%0d at t+%0d",
                 rk_t[j], dout, lat, exp_t[j], lat_t[j]);
      end
      tick();
    end
  endtask

  task automatic test_ties();
    int lat;
    logic [7:0] dout;
    set_win(72'h00_00_00_00_00_00_00_00_00);
    run_window(4'd4, 4'd4, 1'b0, lat, dout);
    vectors++;
    if (lat !== 46 || dout !== 8'd0) begin
      miscompares++;
      $display("FAIL ties_zero: DO=%0d at t+%0d, required DO=0 at t+46", dout, lat);
    end
    tick();
    set_win(72'hFF_FF_FF_FF_FF_FF_FF_FF_FF);
    run_window(4'd4, 4'd4, 1'b0, lat, dout);
    vectors++;
    if (lat !== 46 || dout !== 8'd255) begin
      miscompares++;
      $display("FAIL ties_ones: DO=%0d at t+%0d, required DO=255 at t+46", dout, lat);
    end
    tick();
  endtask

  // DSI gaps during LOAD, DOR held low after DSO, upstream holds a sample
  // through OUT and the handshake cycle (must not be consumed).
  task automatic test_gaps_backpressure();
    int lat;
    logic [7:0] dout;
    set_win(72'h09_03_07_01_05_08_02_06_04);
    bus.DOR = 1'b0;
    run_window(4'd4, 4'd4, 1'b1, lat, dout);
    vectors++;
    if (lat !== 46 || dout !== 8'd5 || bus.DI_RDY !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_result: DO=%0d at t+%0d DI_RDY=%b, required DO=5 at t+46 DI_RDY=0",
               dout, lat, bus.DI_RDY);
    end
    bus.DSI = 1'b1;
    bus.DI  = 8'hAA;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (bus.DSO !== 1'b1 || bus.DO !== 8'd5 || bus.DI_RDY !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_%0d: DSO=%b DO=%0d DI_RDY=%b, required 1/5/0", k, bus.DSO, bus.DO, bus.DI_RDY);
      end
    end
    bus.DOR = 1'b1;
    tick();
    bus.DSI = 1'b0;
    vectors++;
    if (bus.DSO !== 1'b0 || bus.DO !== 8'd5 || bus.DI_RDY !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: DSO=%b DO=%0d DI_RDY=%b, required 0/5/1", bus.DSO, bus.DO, bus.DI_RDY);
    end
  endtask

  task automatic test_rank_clamp();
    int lat;
    logic [7:0] dout;
    set_win(72'h09_03_07_01_05_08_02_06_04);
    run_window(4'd15, 4'd15, 1'b0, lat, dout);
    vectors++;
    if (lat !== 10 || dout !== 8'd9) begin
      miscompares++;
      $display("FAIL rank_clamp: DO=%0d at t+%0d, required DO=9 at t+10", dout, lat);
    end
    tick();
    run_window(4'd4, 4'd0, 1'b0, lat, dout);
    vectors++;
    if (lat !== 46 || dout !== 8'd5) begin
      miscompares++;
      $display("FAIL rank_late_change: DO=%0d at t+%0d, required DO=5 at t+46", dout, lat);
    end
    tick();
  endtask

  task automatic test_reset_mid_sort();
    int lat;
    logic [7:0] dout;
    set_win(72'h09_03_07_01_05_08_02_06_04);
    bus.RANK = 4'd4;
    for (int i = 0; i < 9; i++) begin
      bus.DSI = 1'b1;
      bus.DI  = win[i];
      tick();
    end
    bus.DSI = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    vectors++;
    if (bus.DSO !== 1'b0 || bus.DI_RDY !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_sort_state: DSO=%b DI_RDY=%b, required 0/0", bus.DSO, bus.DI_RDY);
    end
    #2 nRST = 1'b0;
    #1;
    vectors++;
    if (bus.DSO !== 1'b0 || bus.DO !== 8'd0 || bus.DI_RDY !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_sort_reset: DSO=%b DO=%0d DI_RDY=%b, required 0/0/1", bus.DSO, bus.DO, bus.DI_RDY);
    end
    @(posedge CLK);
    #1 nRST = 1'b1;
    run_window(4'd6, 4'd6, 1'b0, lat, dout);
    vectors++;
    if (lat !== 28 || dout !== 8'd7) begin
      miscompares++;
      $display("FAIL after_reset_window: DO=%0d at t+%0d, required DO=7 at t+28", dout, lat);
    end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRST        = 1'b1;
    bus.DI      = '0;
    bus.DSI     = 1'b0;
    bus.RANK    = '0;
    bus.DOR     = 1'b1;
    test_reset();
    test_median();
    test_rank_extremes();
    test_ties();
    test_gaps_backpressure();
    test_rank_clamp();
    test_reset_mid_sort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
